// File: rtl/load_store_unit.sv
// Load/store sequencer between a decoded instruction stream, a register file and
// a data memory with a bounded wait for the memory acknowledge.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [3:0]  rf_raddr,
    input  logic [15:0] rf_rdata,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        done,
    output logic        err_illegal,
    output logic        err_timeout
);

    localparam int unsigned CNT_W = 8;
    localparam logic [3:0]  OP_LOAD  = 4'b0000;
    localparam logic [3:0]  OP_STORE = 4'b0001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEM  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [3:0]         opcode;
    logic               accept_mem;
    logic               illegal;
    logic               ack_hit;
    logic               expired;

    assign opcode   = instr[3:0];
    assign rf_raddr = instr[7:4];
    assign cnt_inc  = cnt_q + CNT_W'(1);

    // Next-state and event decode; ack is checked before the wait limit so it wins.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept_mem = 1'b0;
        illegal    = 1'b0;
        ack_hit    = 1'b0;
        expired    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    if (opcode == OP_LOAD || opcode == OP_STORE) begin
                        accept_mem = 1'b1;
                        cnt_d      = '0;
                        state_d    = S_MEM;
                    end else begin
                        illegal = 1'b1;
                    end
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    ack_hit = 1'b1;
                    state_d = mem_we ? S_IDLE : S_WB;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    expired = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, captured operands and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            instr_ready <= 1'b1;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            instr_ready <= (state_d == S_IDLE);
            mem_req     <= (state_d == S_MEM);
            rf_we       <= (state_d == S_WB);
            done        <= ack_hit;
            err_illegal <= illegal;
            err_timeout <= expired;
            if (accept_mem) begin
                mem_addr <= instr[15:8];
                mem_we   <= (opcode == OP_STORE);
                if (opcode == OP_STORE) begin
                    mem_wdata <= rf_rdata;
                end else begin
                    rf_waddr <= instr[7:4];
                end
            end
            if (ack_hit && !mem_we) begin
                rf_wdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios then random load/store/illegal
// traffic checked against register-file and memory array models.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  rf_raddr;
    logic [15:0] rf_rdata;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        done;
    logic        err_illegal;
    logic        err_timeout;

    logic [15:0] rf_model [16];
    logic [15:0] mem_model [256];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign rf_rdata = rf_model[rf_raddr];

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .rf_raddr   (rf_raddr),
        .rf_rdata   (rf_rdata),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .done       (done),
        .err_illegal(err_illegal),
        .err_timeout(err_timeout)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction from accept to return to idle; ack_wait >= TO means no ack.
    task automatic run_op(input logic [15:0] ins, input int ack_wait);
        logic [3:0]  op;
        logic [3:0]  idx;
        logic [7:0]  addr;
        logic [15:0] sdata;
        logic        is_mem;
        logic        completes;
        int          mem_cycles;
        op         = ins[3:0];
        idx        = ins[7:4];
        addr       = ins[15:8];
        is_mem     = (op == 4'd0) || (op == 4'd1);
        completes  = is_mem && (ack_wait < TO);
        mem_cycles = completes ? ack_wait + 1 : TO;
        sdata      = rf_model[idx];
        chk("ready_before", 16'(instr_ready), 16'd1);
        instr       = ins;
        instr_valid = 1'b1;
        step();
        instr       = 16'($urandom);
        instr_valid = 1'b0;
        if (!is_mem) begin
            chk("illegal_pulse", 16'(err_illegal), 16'd1);
            chk("illegal_no_req", 16'(mem_req), 16'd0);
            chk("illegal_ready", 16'(instr_ready), 16'd1);
            chk("illegal_no_done", 16'(done), 16'd0);
            step();
            chk("illegal_once", 16'(err_illegal), 16'd0);
            chk("illegal_no_req2", 16'(mem_req), 16'd0);
            return;
        end
        for (int k = 0; k < mem_cycles; k++) begin
            chk("mem_req", 16'(mem_req), 16'd1);
            chk("mem_addr", 16'(mem_addr), 16'(addr));
            chk("mem_we", 16'(mem_we), 16'(op == 4'd1));
            if (op == 4'd1) chk("mem_wdata", mem_wdata, sdata);
            chk("mem_no_rf_we", 16'(rf_we), 16'd0);
            chk("mem_not_ready", 16'(instr_ready), 16'd0);
            mem_ack   = completes && (k == ack_wait);
            mem_rdata = mem_ack ? mem_model[addr] : 16'($urandom);
            step();
        end
        mem_ack   = 1'($urandom);
        mem_rdata = 16'($urandom);
        chk("req_dropped", 16'(mem_req), 16'd0);
        if (!completes) begin
            chk("timeout_pulse", 16'(err_timeout), 16'd1);
            chk("timeout_no_done", 16'(done), 16'd0);
            chk("timeout_no_rf_we", 16'(rf_we), 16'd0);
            chk("timeout_ready", 16'(instr_ready), 16'd1);
        end else if (op == 4'd0) begin
            chk("ld_rf_we", 16'(rf_we), 16'd1);
            chk("ld_rf_waddr", 16'(rf_waddr), 16'(idx));
            chk("ld_rf_wdata", rf_wdata, mem_model[addr]);
            chk("ld_done", 16'(done), 16'd1);
            chk("ld_no_timeout", 16'(err_timeout), 16'd0);
            chk("ld_wb_not_ready", 16'(instr_ready), 16'd0);
            rf_model[idx] = mem_model[addr];
            step();
            chk("ld_rf_we_once", 16'(rf_we), 16'd0);
            chk("ld_done_once", 16'(done), 16'd0);
            chk("ld_ready_after", 16'(instr_ready), 16'd1);
        end else begin
            chk("st_done", 16'(done), 16'd1);
            chk("st_no_rf_we", 16'(rf_we), 16'd0);
            chk("st_no_timeout", 16'(err_timeout), 16'd0);
            chk("st_ready", 16'(instr_ready), 16'd1);
            mem_model[addr] = sdata;
        end
        step();
        chk("idle_no_done", 16'(done), 16'd0);
        chk("idle_no_timeout", 16'(err_timeout), 16'd0);
        chk("stray_ack_no_req", 16'(mem_req), 16'd0);
        chk("stray_ack_no_rf_we", 16'(rf_we), 16'd0);
        mem_ack = 1'b0;
    endtask

    initial begin
        int kind;
        for (int i = 0; i < 16; i++) rf_model[i] = 16'($urandom);
        for (int i = 0; i < 256; i++) mem_model[i] = 16'($urandom);
        rst_n       = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;

        // Reset values.
        step();
        step();
        chk("rst_mem_req", 16'(mem_req), 16'd0);
        chk("rst_mem_we", 16'(mem_we), 16'd0);
        chk("rst_mem_addr", 16'(mem_addr), 16'd0);
        chk("rst_mem_wdata", mem_wdata, 16'd0);
        chk("rst_rf_we", 16'(rf_we), 16'd0);
        chk("rst_rf_waddr", 16'(rf_waddr), 16'd0);
        chk("rst_rf_wdata", rf_wdata, 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_err", 16'({err_illegal, err_timeout}), 16'd0);
        rst_n = 1'b1;
        chk("rst_ready", 16'(instr_ready), 16'd1);

        // Load with ack in the first MEM cycle.
        mem_model[8'h42] = 16'hBEEF;
        run_op(16'h4230, 0);
        chk("ld_model_r3", rf_model[3], 16'hBEEF);

        // Store after three wait cycles.
        rf_model[5] = 16'h1234;
        run_op(16'h1051, 3);

        // Illegal opcode.
        run_op(16'h00A7, 0);

        // Timeout then ack on the last allowed cycle.
        run_op(16'h2360, TO);
        run_op(16'h2360, TO - 1);

        // Reset during the second MEM cycle, then a late ack.
        instr       = 16'h5540;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk("rstmid_req1", 16'(mem_req), 16'd1);
        step();
        chk("rstmid_req2", 16'(mem_req), 16'd1);
        rst_n = 1'b0;
        step();
        chk("rstmid_req", 16'(mem_req), 16'd0);
        chk("rstmid_addr", 16'(mem_addr), 16'd0);
        chk("rstmid_we", 16'(mem_we), 16'd0);
        chk("rstmid_rf_we", 16'(rf_we), 16'd0);
        chk("rstmid_rf_waddr", 16'(rf_waddr), 16'd0);
        chk("rstmid_pulses", 16'({done, err_illegal, err_timeout}), 16'd0);
        chk("rstmid_ready", 16'(instr_ready), 16'd1);
        rst_n     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        step();
        chk("late_ack_rf_we", 16'(rf_we), 16'd0);
        chk("late_ack_done", 16'(done), 16'd0);
        chk("late_ack_req", 16'(mem_req), 16'd0);
        chk("late_ack_rf_wdata", rf_wdata, 16'd0);
        mem_ack = 1'b0;
        step();
        chk("late_ack_done2", 16'(done), 16'd0);
        chk("late_ack_rf_we2", 16'(rf_we), 16'd0);

        // Back-to-back load then store of the loaded register, valid held high.
        instr       = 16'h7720;
        instr_valid = 1'b1;
        step();
        chk("b2b_ld_req", 16'(mem_req), 16'd1);
        chk("b2b_ld_addr", 16'(mem_addr), 16'h77);
        instr     = 16'h8821;
        mem_ack   = 1'b1;
        mem_rdata = mem_model[8'h77];
        step();
        mem_ack = 1'b0;
        chk("b2b_ld_rf_we", 16'(rf_we), 16'd1);
        chk("b2b_ld_wdata", rf_wdata, mem_model[8'h77]);
        chk("b2b_ld_done", 16'(done), 16'd1);
        chk("b2b_wb_not_ready", 16'(instr_ready), 16'd0);
        rf_model[2] = mem_model[8'h77];
        step();
        chk("b2b_st_not_taken", 16'(mem_req), 16'd0);
        chk("b2b_ready", 16'(instr_ready), 16'd1);
        chk("b2b_no_done", 16'(done), 16'd0);
        step();
        instr_valid = 1'b0;
        chk("b2b_st_req", 16'(mem_req), 16'd1);
        chk("b2b_st_we", 16'(mem_we), 16'd1);
        chk("b2b_st_addr", 16'(mem_addr), 16'h88);
        chk("b2b_st_wdata", mem_wdata, rf_model[2]);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("b2b_st_done", 16'(done), 16'd1);
        chk("b2b_st_no_rf_we", 16'(rf_we), 16'd0);
        mem_model[8'h88] = rf_model[2];
        step();
        chk("b2b_done_once", 16'(done), 16'd0);

        // Random traffic against the array models.
        for (int n = 0; n < 60; n++) begin
            logic [15:0] ins;
            ins  = 16'($urandom);
            kind = int'($urandom_range(0, 4));
            if (kind < 2)      ins[3:0] = 4'd0;
            else if (kind < 4) ins[3:0] = 4'd1;
            else               ins[3:0] = 4'(2 + $urandom_range(0, 13));
            run_op(ins, int'($urandom_range(0, TO)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16, means the maximum cycles in MEM awaiting mem_ack before abort (legal range 1..255).
REQ-002 Clocking: one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 instr  in  16  decoded-stream instruction: [3:0] opcode, [7:4] register index, [15:8] memory address.
REQ-006 instr_valid  in  1  instr present this cycle.
REQ-007 instr_ready  out  1  unit can accept instr; high only in IDLE.
REQ-008 rf_raddr  out  4  register-file read index, combinational = instr[7:4].
REQ-009 rf_rdata  in  16  register-file read data, combinational from rf_raddr.
REQ-010 rf_we / rf_waddr / rf_wdata  out  1/4/16  register-file write port.
REQ-011 mem_req / mem_we / mem_addr / mem_wdata  out  1/1/8/16  data-memory request.
REQ-012 mem_ack / mem_rdata  in  1/16  memory completion and load data.
REQ-013 done  out  1  one-cycle pulse per completed load/store.
REQ-014 err_illegal / err_timeout  out  1/1  one-cycle error pulses.

Function
REQ-015 The unit SHALL implement states IDLE, MEM, WB.
REQ-016 Handshake: an instruction is accepted on a rising edge with instr_valid=1 and instr_ready=1; instr need not be held afterwards.
REQ-017 Opcode 4'b0000 (load) SHALL move IDLE->MEM with mem_we=0, capturing address instr[15:8] and destination index instr[7:4].
REQ-018 Opcode 4'b0001 (store) SHALL move IDLE->MEM with mem_we=1, capturing mem_addr=instr[15:8] and mem_wdata=rf_rdata at the accept edge.
REQ-019 Any other opcode SHALL be consumed, keep state IDLE, and pulse err_illegal in the following cycle; no memory or register activity.
REQ-020 In MEM, mem_req SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL be stable until the cycle ack is sampled or timeout occurs.
REQ-021 mem_ack sampled high in any MEM cycle, including the first, completes the access.
REQ-022 Load completion: capture mem_rdata, move MEM->WB; in WB rf_we=1, rf_waddr=captured index, rf_wdata=captured data, done=1 for exactly that cycle; then WB->IDLE.
REQ-023 Store completion: move MEM->IDLE; done=1 in the first IDLE cycle; rf_we stays 0.
REQ-024 Latency with ack in first MEM cycle: load accept edge at cycle 0 -> mem_req cycle 1 -> rf_we/done cycle 2 -> instr_ready cycle 3; store -> done and instr_ready cycle 2.
REQ-025 A cycle counter SHALL clear on MEM entry and increment each MEM cycle without ack; when it reaches TIMEOUT, the unit SHALL drop mem_req, return to IDLE, pulse err_timeout next cycle, and perform no register write.
REQ-026 Ack on the same cycle the counter reaches TIMEOUT SHALL count as completion (ack wins); no err_timeout.
REQ-027 mem_ack while not in MEM SHALL be ignored.
REQ-028 rf_we SHALL be 0 in every state other than WB; mem_req SHALL be 0 outside MEM.
REQ-029 done, err_illegal and err_timeout SHALL never assert together and never exceed one cycle.

Reset
REQ-030 On a rising edge with rst_n=0: state=IDLE, counter=0, captured registers=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rf_we=0, rf_waddr=0, rf_wdata=0, done=0, err_illegal=0, err_timeout=0; instr_ready=1 in the first cycle after rst_n returns high.
REQ-031 Reset mid-operation (MEM or WB) SHALL abort without a register write or done/error pulse; a later mem_ack for the aborted request is ignored.

Verification
REQ-032 Load: instr=16'h4230, mem_ack=1 with mem_rdata=16'hBEEF in first MEM cycle -> mem_addr=8'h42, mem_we=0; next cycle rf_we=1, rf_waddr=3, rf_wdata=16'hBEEF, done=1.
REQ-033 Store: instr=16'h1051, rf_rdata=16'h1234 at accept, ack after 3 wait cycles -> mem_req high 4 cycles, mem_addr=8'h10, mem_we=1, mem_wdata=16'h1234, done one cycle after ack, rf_we never high.
REQ-034 Illegal: instr=16'h00A7 accepted -> err_illegal pulse next cycle, mem_req stays 0, instr_ready stays 1.
REQ-035 Timeout: TIMEOUT=4, load with no ack -> mem_req high exactly 4 cycles, err_timeout pulse, no rf_we; repeat with ack on 4th MEM cycle -> load completes normally.
REQ-036 Reset mid-load: rst_n=0 during MEM cycle 2, ack asserted after release -> all outputs at reset values, no rf_we, no done.
REQ-037 Back-to-back: instr_valid held high with load then store -> second accepted only when instr_ready=1, both complete in order with one done each.
